// File: rtl/zebra_frame_binarizer.sv
// zebra_frame_binarizer: thresholds a raster-order grayscale stream into
// 2-bit codes (01 white, 00 black), writes them into the shared image BRAM
// and holds valid_to_read until the detector acknowledges the frame.
// Optional build macro BORDER_CLEAR_EN: outer border pixels are forced to
// black and left out of white_count.
module zebra_frame_binarizer #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIXEL_W    = 8,
    parameter int THRESHOLD  = 128,
    localparam int TOTAL_PIXELS = IMG_WIDTH * IMG_HEIGHT,
    localparam int ADDR_W       = $clog2(TOTAL_PIXELS),
    localparam int CNT_W        = $clog2(TOTAL_PIXELS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [PIXEL_W-1:0] s_data,
    input  logic               s_sof,
    output logic [ADDR_W-1:0]  bram_waddr,
    output logic [1:0]         bram_wdata,
    output logic               bram_we,
    output logic               valid_to_read,
    input  logic               detection_valid,
    output logic [CNT_W-1:0]   white_count,
    output logic               frame_error
);

    localparam logic [PIXEL_W:0]  THR_EXT  = (PIXEL_W + 1)'(THRESHOLD);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(TOTAL_PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FLUSH,
        HANDOFF
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] pix_cnt;
    logic             accept;
    logic             px_border;
    logic             px_white;

    assign accept   = s_valid && s_ready;
    assign px_white = ({1'b0, s_data} >= THR_EXT) && !px_border;

`ifdef BORDER_CLEAR_EN
    localparam int X_W = $clog2(IMG_WIDTH + 1);
    localparam int Y_W = $clog2(IMG_HEIGHT + 1);

    logic [X_W-1:0] x_cnt;
    logic [X_W-1:0] cur_x;
    logic [Y_W-1:0] y_cnt;
    logic [Y_W-1:0] cur_y;

    // Raster position of the pixel on the bus; a start-of-frame pixel is always (0,0)
    always_comb begin
        cur_x     = s_sof ? '0 : x_cnt;
        cur_y     = s_sof ? '0 : y_cnt;
        px_border = (cur_x == '0) || (cur_x == X_W'(IMG_WIDTH - 1)) ||
                    (cur_y == '0) || (cur_y == Y_W'(IMG_HEIGHT - 1));
    end

    // Advance the x/y position on every accepted pixel, wrapping at the row end
    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (accept) begin
            if (cur_x == X_W'(IMG_WIDTH - 1)) begin
                x_cnt <= '0;
                y_cnt <= (cur_y == Y_W'(IMG_HEIGHT - 1)) ? '0 : cur_y + Y_W'(1);
            end else begin
                x_cnt <= cur_x + X_W'(1);
                y_cnt <= cur_y;
            end
        end
    end
`else
    assign px_border = 1'b0;
`endif

    // Frame FSM with registered handshake, BRAM write and handoff outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pix_cnt       <= '0;
            s_ready       <= 1'b0;
            bram_we       <= 1'b0;
            bram_waddr    <= '0;
            bram_wdata    <= '0;
            valid_to_read <= 1'b0;
            white_count   <= '0;
            frame_error   <= 1'b0;
        end else begin
            bram_we     <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                // IDLE and FILL share the start-of-frame path; only FILL reports it as an error
                IDLE, FILL: begin
                    s_ready <= 1'b1;
                    if (accept && s_sof) begin
                        frame_error <= (state == FILL);
                        bram_we     <= 1'b1;
                        bram_waddr  <= '0;
                        bram_wdata  <= {1'b0, px_white};
                        white_count <= CNT_W'(px_white);
                        pix_cnt     <= CNT_W'(1);
                        state       <= FILL;
                    end else if (accept && (state == FILL)) begin
                        bram_we     <= 1'b1;
                        bram_waddr  <= pix_cnt[ADDR_W-1:0];
                        bram_wdata  <= {1'b0, px_white};
                        white_count <= white_count + CNT_W'(px_white);
                        pix_cnt     <= pix_cnt + CNT_W'(1);
                        if (pix_cnt == LAST_IDX) begin
                            s_ready <= 1'b0;
                            state   <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    valid_to_read <= 1'b1;
                    state         <= HANDOFF;
                end
                HANDOFF: begin
                    if (detection_valid) begin
                        valid_to_read <= 1'b0;
                        s_ready       <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    s_ready <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
